// File: rtl/upower_pkg.sv
// Shared types and constants for the uPower sequencing controller.
package upower_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_FAULT
    } upower_state_t;

    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_JMP = 2'd2;

    localparam logic [5:0] OPC_B  = 6'd18;

endpackage

// File: rtl/upower_wait_timer.sv
// Memory-stall watchdog: counts consecutive not-ready wait cycles.
module upower_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [7:0] r_cnt;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Fires on the wait cycle whose increment would reach the limit.
    assign o_expired = i_en && (r_cnt == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/upower_seq_ctrl.sv
// Multi-cycle F/D/E/M/W sequencer with shared memory port and
// retire counter for the uPower core.
module upower_seq_ctrl
    import upower_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int RET_W       = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             is_branch,
    input  logic             is_jump,
    input  logic             reg_write,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_we,
    output logic             reg_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             busy,
    output logic             fault,
    output logic [RET_W-1:0] retired
);

    upower_state_t r_state;
    upower_state_t w_next;

    logic r_ld;
    logic r_st;
    logic r_br;
    logic r_jp;
    logic r_rw;

    logic [RET_W-1:0] r_retired;

    logic w_wait_state;
    logic w_tm_clr;
    logic w_tm_en;
    logic w_expired;

    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_tm_clr     = !w_wait_state || mem_ready;
    assign w_tm_en      = w_wait_state && !mem_ready;

    upower_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .i_clock  (clock),
        .i_reset_n(reset_n),
        .i_clr    (w_tm_clr),
        .i_en     (w_tm_en),
        .o_expired(w_expired)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_ld      <= 1'b0;
            r_st      <= 1'b0;
            r_br      <= 1'b0;
            r_jp      <= 1'b0;
            r_rw      <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            // Store beats load, jump beats branch when both are flagged.
            if (r_state == S_DECODE) begin
                r_st <= is_store;
                r_ld <= is_load && !is_store;
                r_jp <= is_jump;
                r_br <= is_branch && !is_jump;
                r_rw <= reg_write;
            end
            if (pc_we) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        reg_we       = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = PC_SEQ;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we  = 1'b1;
                    w_next = S_DECODE;
                end else if (w_expired) begin
                    w_next = S_FAULT;
                end
            end
            S_DECODE: begin
                w_next = S_EXEC;
            end
            S_EXEC: begin
                if (r_ld || r_st) begin
                    w_next = S_MEM;
                end else if (r_rw) begin
                    w_next = S_WB;
                end else begin
                    pc_we = 1'b1;
                    if (r_jp) begin
                        pc_sel = PC_JMP;
                    end else if (r_br && alu_zero) begin
                        pc_sel = PC_BR;
                    end
                    w_next = stop ? S_IDLE : S_FETCH;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = r_st;
                if (mem_ready) begin
                    if (r_st) begin
                        pc_we  = 1'b1;
                        w_next = stop ? S_IDLE : S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_expired) begin
                    w_next = S_FAULT;
                end
            end
            S_WB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
                w_next = stop ? S_IDLE : S_FETCH;
            end
            S_FAULT: begin
                w_next = S_FAULT;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign busy    = (r_state != S_IDLE) && (r_state != S_FAULT);
    assign fault   = (r_state == S_FAULT);
    assign retired = r_retired;

endmodule

// File: tb/tb_upower_seq_ctrl.sv
// Randomised instruction stream against a per-instruction cycle
// schedule model; directed reset, timeout and stop scenarios.
module tb_upower_seq_ctrl;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       is_load = 1'b0;
    logic       is_store = 1'b0;
    logic       is_branch = 1'b0;
    logic       is_jump = 1'b0;
    logic       reg_write = 1'b0;
    logic       alu_zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_we;
    logic       reg_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       busy;
    logic       fault;
    logic [3:0] retired;

    int         errors = 0;
    int         checks = 0;
    logic [3:0] exp_ret = 4'd0;

    upower_seq_ctrl #(
        .MEM_TIMEOUT(4),
        .RET_W      (4)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .stop        (stop),
        .is_load     (is_load),
        .is_store    (is_store),
        .is_branch   (is_branch),
        .is_jump     (is_jump),
        .reg_write   (reg_write),
        .alu_zero    (alu_zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr_sel(mem_addr_sel),
        .ir_we       (ir_we),
        .reg_we      (reg_we),
        .pc_we       (pc_we),
        .pc_sel      (pc_sel),
        .busy        (busy),
        .fault       (fault),
        .retired     (retired)
    );

    always #5 clock = ~clock;

    // Expected control vector: req we asel ir rg pcw psel busy fault
    function automatic logic [9:0] ev(bit req, bit we, bit asel,
                                      bit ir, bit rg, bit pcw,
                                      logic [1:0] ps, bit bsy, bit flt);
        return {req, we, asel, ir, rg, pcw, ps, bsy, flt};
    endfunction

    // Inputs that must not matter in the current cycle get random values.
    task automatic noise();
        start     = 1'($urandom);
        stop      = 1'($urandom);
        is_load   = 1'($urandom);
        is_store  = 1'($urandom);
        is_branch = 1'($urandom);
        is_jump   = 1'($urandom);
        reg_write = 1'($urandom);
        alu_zero  = 1'($urandom);
    endtask

    task automatic chk(string tag, logic [9:0] e);
        logic [13:0] obs;
        logic [13:0] ex;
        @(negedge clock);
        obs = {mem_req, mem_we, mem_addr_sel, ir_we, reg_we, pc_we,
               pc_sel, busy, fault, retired};
        ex  = {e, exp_ret};
        checks++;
        assert (obs === ex) else begin
            errors++;
            $error("FAIL %s t=%0t observed=%h expected=%h",
                   tag, $time, obs, ex);
        end
        if (e[4]) exp_ret = exp_ret + 4'd1;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        noise();
        reset_n   = 1'b0;
        mem_ready = 1'($urandom);
        @(posedge clock);
        #1;
        exp_ret = 4'd0;
        chk("reset", ev(0, 0, 0, 0, 0, 0, 2'd0, 0, 0));
        reset_n = 1'b1;
    endtask

    task automatic idle(bit go);
        noise();
        start     = go;
        mem_ready = 1'($urandom);
        chk(go ? "idle_start" : "idle_hold",
            ev(0, 0, 0, 0, 0, 0, 2'd0, 0, 0));
    endtask

    // One instruction: fw/mw are not-ready cycles before ready in F/M.
    task automatic run_instr(string tag, bit ld, bit st, bit br,
                             bit jp, bit rw, bit z, bit stp,
                             int fw, int mw);
        bit         mem;
        bit         is_st;
        bit         is_ld;
        bit         ex_ret;
        logic [1:0] ps;
        mem    = ld || st;
        is_st  = st;
        is_ld  = ld && !st;
        ex_ret = !mem && !rw;
        for (int k = 0; k <= fw; k++) begin
            noise();
            mem_ready = (k == fw);
            chk({tag, "_F"}, ev(1, 0, 0, k == fw, 0, 0, 2'd0, 1, 0));
        end
        noise();
        is_load   = ld;
        is_store  = st;
        is_branch = br;
        is_jump   = jp;
        reg_write = rw;
        mem_ready = 1'($urandom);
        chk({tag, "_D"}, ev(0, 0, 0, 0, 0, 0, 2'd0, 1, 0));
        noise();
        alu_zero  = z;
        mem_ready = 1'($urandom);
        if (ex_ret) stop = stp;
        ps = !ex_ret ? 2'd0 : jp ? 2'd2 : (br && z) ? 2'd1 : 2'd0;
        chk({tag, "_E"}, ev(0, 0, 0, 0, 0, ex_ret, ps, 1, 0));
        if (mem) begin
            for (int k = 0; k <= mw; k++) begin
                noise();
                mem_ready = (k == mw);
                if (k == mw && is_st) stop = stp;
                chk({tag, "_M"}, ev(1, is_st, 1, 0, 0, k == mw && is_st,
                                    2'd0, 1, 0));
            end
        end
        if (is_ld || (!mem && rw)) begin
            noise();
            stop      = stp;
            mem_ready = 1'($urandom);
            chk({tag, "_W"}, ev(0, 0, 0, 0, 1, 1, 2'd0, 1, 0));
        end
    endtask

    initial begin
        bit running;
        do_reset();
        do_reset();

        idle(0);
        idle(1);
        run_instr("alu", 0, 0, 0, 0, 1, 0, 0, 0, 0);
        run_instr("beq_t", 0, 0, 1, 0, 0, 1, 0, 0, 0);
        run_instr("beq_f", 0, 0, 1, 0, 0, 0, 0, 0, 0);
        run_instr("jmp", 0, 0, 1, 1, 0, 0, 0, 0, 0);
        run_instr("ld_w3", 1, 0, 0, 0, 1, 0, 0, 0, 3);
        run_instr("ldst", 1, 1, 0, 0, 1, 0, 0, 3, 1);
        run_instr("st_stop", 0, 1, 0, 0, 0, 0, 1, 1, 0);
        idle(0);

        // stop and start together in IDLE: one instruction then IDLE.
        noise();
        start     = 1'b1;
        stop      = 1'b1;
        mem_ready = 1'($urandom);
        chk("idle_both", ev(0, 0, 0, 0, 0, 0, 2'd0, 0, 0));
        run_instr("both", 0, 0, 0, 0, 1, 0, 1, 0, 0);
        idle(0);

        running = 1'b0;
        for (int i = 0; i < 80; i++) begin
            bit stp;
            stp = ($urandom_range(0, 5) == 0);
            if (!running) begin
                if ($urandom_range(0, 1) == 1) idle(0);
                idle(1);
                running = 1'b1;
            end
            run_instr("rnd", 1'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom), 1'($urandom), stp,
                      $urandom_range(0, 3), $urandom_range(0, 3));
            if (stp) running = 1'b0;
        end
        if (running) begin
            run_instr("tail", 0, 0, 0, 0, 1, 0, 1, 0, 0);
        end
        idle(0);

        // Reset during a fetch wait.
        idle(1);
        for (int k = 0; k < 2; k++) begin
            noise();
            mem_ready = 1'b0;
            chk("rst_fw", ev(1, 0, 0, 0, 0, 0, 2'd0, 1, 0));
        end
        do_reset();
        idle(0);

        // Fetch timeout after the 4th wait cycle.
        idle(1);
        for (int k = 0; k < 4; k++) begin
            noise();
            mem_ready = 1'b0;
            chk("to_fetch", ev(1, 0, 0, 0, 0, 0, 2'd0, 1, 0));
        end
        for (int k = 0; k < 5; k++) begin
            noise();
            mem_ready = 1'($urandom);
            chk("fault_f", ev(0, 0, 0, 0, 0, 0, 2'd0, 0, 1));
        end
        do_reset();

        // Data-phase timeout during a load.
        idle(1);
        run_instr("pre", 0, 0, 0, 0, 1, 0, 0, 2, 0);
        noise();
        mem_ready = 1'b1;
        chk("ldto_F", ev(1, 0, 0, 1, 0, 0, 2'd0, 1, 0));
        noise();
        is_load   = 1'b1;
        is_store  = 1'b0;
        mem_ready = 1'($urandom);
        chk("ldto_D", ev(0, 0, 0, 0, 0, 0, 2'd0, 1, 0));
        noise();
        mem_ready = 1'($urandom);
        chk("ldto_E", ev(0, 0, 0, 0, 0, 0, 2'd0, 1, 0));
        for (int k = 0; k < 4; k++) begin
            noise();
            mem_ready = 1'b0;
            chk("ldto_M", ev(1, 0, 1, 0, 0, 0, 2'd0, 1, 0));
        end
        for (int k = 0; k < 3; k++) begin
            noise();
            mem_ready = 1'($urandom);
            chk("fault_m", ev(0, 0, 0, 0, 0, 0, 2'd0, 0, 1));
        end
        do_reset();
        idle(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/upower_seq_ctrl.md
# upower_seq_ctrl

Multi-cycle sequencing controller for the uPower core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It shares the single memory port between instruction fetch and load/store data access using a req/ready handshake. It also generates the PC, instruction-register and register-file write strobes that the core datapath consumes. The core's decode logic feeds it instruction-class flags and the ALU zero result; a memory-stall watchdog guards every memory wait.

## Interface
- `MEM_TIMEOUT`, 15: max consecutive cycles `mem_ready` may stay low during one memory wait before FAULT; range 1–255.
- `RET_W`, 32: width of the retired-instruction counter.

- `clock`  in  1  single clock; all state changes on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  leave IDLE and begin fetching at current PC.
- `stop`  in  1  sampled at retire; 1 returns to IDLE after the retiring instruction.
- `is_load`  in  1  decode flag, valid in DECODE.
- `is_store`  in  1  decode flag, valid in DECODE.
- `is_branch`  in  1  conditional branch, valid in DECODE.
- `is_jump`  in  1  unconditional jump (opcode 18), valid in DECODE.
- `reg_write`  in  1  instruction writes a GPR, valid in DECODE.
- `alu_zero`  in  1  ALU result == 0, valid in EXEC.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `mem_req`  out  1  memory request active.
- `mem_we`  out  1  write request (store); 0 for fetch/load.
- `mem_addr_sel`  out  1  0 = PC (fetch), 1 = ALU result (data).
- `ir_we`  out  1  capture instruction word.
- `reg_we`  out  1  register-file write strobe.
- `pc_we`  out  1  update PC (retire).
- `pc_sel`  out  2  0 = PC+1, 1 = PC+1+bd, 2 = li; 0 whenever `pc_we` = 0.
- `busy`  out  1  state ≠ IDLE and ≠ FAULT.
- `fault`  out  1  sticky memory-timeout indication.
- `retired`  out  RET_W  count of retired instructions, wraps.

## Operation
- **Reset values.** State IDLE. All outputs 0, `retired` 0. Flag latches and wait counter cleared.
- **IDLE.**
  - `start` = 1 → FETCH.
  - `stop` has no effect in IDLE.
- **FETCH.**
  - Outputs: `mem_req` = 1, `mem_we` = 0, `mem_addr_sel` = 0.
  - On `mem_ready` = 1: `ir_we` = 1 in the same cycle (Mealy), → DECODE.
- **DECODE.**
  - Latch `is_load`, `is_store`, `is_branch`, `is_jump`, `reg_write`.
  - Always → EXEC.
- **EXEC.**
  - Load or store → MEM.
  - Else `reg_write` → WB.
  - Else retire from EXEC:
    - `pc_we` = 1.
    - `pc_sel` = 2 if jump; 1 if branch and `alu_zero` = 1; else 0.
- **MEM.**
  - Outputs: `mem_req` = 1, `mem_addr_sel` = 1, `mem_we` = latched `is_store`.
  - On `mem_ready`: load → WB; store → retire with `pc_sel` = 0.
- **WB.**
  - `reg_we` = 1, `pc_we` = 1, `pc_sel` = 0; retire.
- **Retire.**
  - `retired` += 1, wrapping modulo 2^RET_W.
  - Next state is IDLE if `stop` = 1, else FETCH.
- **Watchdog.**
  - Wait counter clears on entry to FETCH/MEM and on every `mem_ready`.
  - It increments each FETCH/MEM cycle with `mem_ready` = 0.
  - When the counter would reach `MEM_TIMEOUT`: → FAULT, `fault` = 1, `mem_req` dropped.
  - If `mem_ready` = 1 in the same cycle, ready wins.
- **FAULT.** Absorbing; only `reset_n` exits. All strobes 0.
- **Illegal flag combinations.**
  - `is_load` and `is_store` both set: treated as store.
  - `is_jump` overrides `is_branch`.

## Timing
- Zero-wait memory (`mem_ready` = 1 in the first request cycle) gives these cycles per instruction:
  - Branch/jump: 3 (F, D, E).
  - ALU op: 4 (F, D, E, W).
  - Store: 4 (F, D, E, M).
  - Load: 5 (F, D, E, M, W).
- Each memory wait cycle adds 1.
- `mem_req` stays high every cycle of a wait until the `mem_ready` cycle, inclusive. It drops the following cycle unless the next state also requests.
- `pc_we`, `reg_we` and `ir_we` are single-cycle pulses.
- The `retired` update is visible the cycle after `pc_we`.
- Reset asserted mid-operation (including during a memory wait) forces IDLE and all-zero outputs at that edge. No retire is counted.
- `stop` and `start` both high in IDLE: `start` wins (one instruction runs, then `stop` is re-sampled at retire).

## Structure
- Shared package `upower_pkg`:
  - State encoding `upower_state_t` (IDLE, FETCH, DECODE, EXEC, MEM, WB, FAULT).
  - `pc_sel` constants `PC_SEQ` = 0, `PC_BR` = 1, `PC_JMP` = 2.
  - `OPC_B` = 18.
- One sub-module, `upower_wait_timer`: clear/enable/expired counter parameterised by `MEM_TIMEOUT`.
- The FSM and retire counter live in the top module.

## Test plan
- Reset, `start` = 1, ALU op (`reg_write` = 1), `mem_ready` tied 1 → `ir_we` at cycle 1, `reg_we` + `pc_we` (`pc_sel` 0) at cycle 4, `retired` = 1.
- Branch with `alu_zero` = 1 → `pc_we` with `pc_sel` = 1 in EXEC (cycle 3). Repeat with `alu_zero` = 0 → `pc_sel` = 0. Jump → `pc_sel` = 2.
- Load with `mem_ready` delayed 3 cycles in MEM → `mem_req` = 1, `mem_addr_sel` = 1, `mem_we` = 0 for 4 cycles, then `reg_we` next cycle, total 8 cycles.
- `MEM_TIMEOUT` = 4, `mem_ready` held 0 in FETCH → `fault` = 1 after the 4th wait cycle, `busy` = 0, no strobes until `reset_n` = 0.
- `stop` = 1 during a store's MEM cycle → retire, then IDLE. Separately, `reset_n` = 0 during a FETCH wait → all outputs 0 next cycle, `retired` unchanged from 0.
- Preload `retired` = 2^RET_W − 1 (RET_W = 4, 15 instructions), retire one more → `retired` = 0.
